// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// Words arrive as {hi, lo} byte pairs; a count byte of zero stands for a full 256-word image.
package prog_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      WHI,
      WLO,
      WR,
      CSUM,
      DONE
   } state_e;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
   localparam int         BYTES_PER_WORD    = 2;
   localparam int         MAX_WORDS         = 256;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input handshake plus program-RAM write port and CPU control of the loader.
// The loader side uses the slave modport; the byte source / RAM / CPU side uses master.
interface prog_loader_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 12
);

   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_din;
   logic                  mem_we;
   logic                  cpu_hold;
   logic                  done;
   logic                  err;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  mem_addr,
      input  mem_din,
      input  mem_we,
      input  cpu_hold,
      input  done,
      input  err
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output mem_addr,
      output mem_din,
      output mem_we,
      output cpu_hold,
      output done,
      output err
   );

endinterface

// File: rtl/prog_loader.sv
// Program loader: unpacks a framed byte stream into RAM words, holding the CPU until the
// frame checksum verifies. All outputs are registered, computed from the next state.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int         ADDR_WIDTH = 8,
   parameter int         DATA_WIDTH = 12,
   parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
   input  logic         clk,
   input  logic         rst_n,
   prog_loader_if.slave bus
);

   localparam int HI_BITS = DATA_WIDTH - 8 * (BYTES_PER_WORD - 1);

   state_e                state_q,    state_d;
   logic                  in_ready_q, in_ready_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_din_q,  mem_din_d;
   logic                  mem_we_q,   mem_we_d;
   logic                  cpu_hold_q, cpu_hold_d;
   logic                  done_q,     done_d;
   logic                  err_q,      err_d;
   logic [HI_BITS-1:0]    hi_q,       hi_d;
   logic [7:0]            sum_q,      sum_d;
   logic [8:0]            remain_q,   remain_d;
   logic                  nib_err_q,  nib_err_d;

   logic                  xfer;
   logic                  is_sync;
   logic [7:0]            csum_total;
   logic                  csum_ok;
   logic                  hi_overflow;

   assign xfer        = bus.in_valid && in_ready_q;
   assign is_sync     = (bus.in_data == SYNC_BYTE);
   assign csum_total  = sum_q + bus.in_data;
   assign csum_ok     = (csum_total == 8'd0) && !nib_err_q;
   // Any hi-byte bits that would fall above the RAM word width mark the image as corrupt.
   assign hi_overflow = (({bus.in_data, 8'h00}) >> DATA_WIDTH) != 16'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         in_ready_q <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         mem_we_q   <= 1'b0;
         cpu_hold_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         hi_q       <= '0;
         sum_q      <= '0;
         remain_q   <= '0;
         nib_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         mem_we_q   <= mem_we_d;
         cpu_hold_q <= cpu_hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
         hi_q       <= hi_d;
         sum_q      <= sum_d;
         remain_q   <= remain_d;
         nib_err_q  <= nib_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (xfer && is_sync) state_d = COUNT;
         COUNT:   if (xfer) state_d = WHI;
         WHI:     if (xfer) state_d = WLO;
         WLO:     if (xfer) state_d = WR;
         WR:      state_d = (remain_q == 9'd1) ? CSUM : WHI;
         CSUM:    if (xfer) state_d = csum_ok ? DONE : IDLE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake and strobe outputs are registered from the next state so they line up with it.
   always_comb begin
      case (state_d)
         IDLE, COUNT, WHI, WLO, CSUM: in_ready_d = 1'b1;
         default:                     in_ready_d = 1'b0;
      endcase
      mem_we_d   = (state_d == WR);
      done_d     = (state_d == DONE);

      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      cpu_hold_d = cpu_hold_q;
      err_d      = err_q;
      hi_d       = hi_q;
      sum_d      = sum_q;
      remain_d   = remain_q;
      nib_err_d  = nib_err_q;

      case (state_q)
         IDLE: begin
            if (xfer && is_sync) begin
               cpu_hold_d = 1'b1;
               err_d      = 1'b0;
               mem_addr_d = '0;
               sum_d      = '0;
               nib_err_d  = 1'b0;
            end
         end
         COUNT: begin
            if (xfer) begin
               remain_d = (bus.in_data == 8'd0) ? 9'(MAX_WORDS) : {1'b0, bus.in_data};
               sum_d    = csum_total;
            end
         end
         WHI: begin
            if (xfer) begin
               hi_d  = bus.in_data[HI_BITS-1:0];
               sum_d = csum_total;
               if (hi_overflow) begin
                  nib_err_d = 1'b1;
               end
            end
         end
         WLO: begin
            if (xfer) begin
               mem_din_d = {hi_q, bus.in_data};
               sum_d     = csum_total;
            end
         end
         WR: begin
            mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
            remain_d   = remain_q - 9'd1;
         end
         CSUM: begin
            if (xfer && !csum_ok) begin
               err_d = 1'b1;
            end
         end
         DONE: begin
            cpu_hold_d = 1'b0;
         end
         default: begin
         end
      endcase
   end

   assign bus.in_ready = in_ready_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_din  = mem_din_q;
   assign bus.mem_we   = mem_we_q;
   assign bus.cpu_hold = cpu_hold_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: hand-computed frames, each check an immediate assertion.
// A negedge monitor records every RAM write and done pulse for the end-of-frame checks.
module tb_prog_loader;

   logic clk = 1'b0;
   logic rst_n;

   int checkCount = 0;
   int errorCount = 0;
   int doneCount  = 0;
   int badEntries;

   logic [7:0]  wrAddr[$];
   logic [11:0] wrData[$];
   logic [7:0]  frame[$];

   prog_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(12)) bus ();

   prog_loader #(
      .ADDR_WIDTH(8),
      .DATA_WIDTH(12),
      .SYNC_BYTE (8'hA5)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Record every cycle with mem_we high, so a stretched pulse shows up as an extra write.
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         wrAddr.push_back(bus.mem_addr);
         wrData.push_back(bus.mem_din);
      end
      if (bus.done === 1'b1) begin
         doneCount++;
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         errorCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Present one byte just after a rising edge and hold it until the loader takes it.
   task automatic applyStimulus(input logic [7:0] b);
      int waited;
      waited = 0;
      @(posedge clk);
      #1;
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (bus.in_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("in_ready handshake", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic sendFrame();
      for (int i = 0; i < frame.size(); i++) begin
         applyStimulus(frame[i]);
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic clearLog();
      wrAddr.delete();
      wrData.delete();
      doneCount = 0;
   endtask

   initial begin
      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;

      // Reset values while reset is held.
      @(negedge clk);
      checkOutput("reset in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("reset mem_addr", 32'(bus.mem_addr), 32'd0);
      checkOutput("reset mem_din",  32'(bus.mem_din),  32'd0);
      checkOutput("reset mem_we",   32'(bus.mem_we),   32'd0);
      checkOutput("reset cpu_hold", 32'(bus.cpu_hold), 32'd0);
      checkOutput("reset done",     32'(bus.done),     32'd0);
      checkOutput("reset err",      32'(bus.err),      32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idleCycles(2);
      checkOutput("idle in_ready", 32'(bus.in_ready), 32'd1);

      // Good frame with per-cycle timing checks.
      clearLog();
      applyStimulus(8'hA5);
      @(negedge clk);
      checkOutput("sync err clear", 32'(bus.err),      32'd0);
      checkOutput("sync cpu_hold",  32'(bus.cpu_hold), 32'd1);
      applyStimulus(8'h02);
      applyStimulus(8'h00);
      applyStimulus(8'hF9);
      @(negedge clk);
      checkOutput("word0 mem_we",   32'(bus.mem_we),   32'd1);
      checkOutput("word0 mem_addr", 32'(bus.mem_addr), 32'h00);
      checkOutput("word0 mem_din",  32'(bus.mem_din),  32'h0F9);
      checkOutput("word0 in_ready", 32'(bus.in_ready), 32'd0);
      applyStimulus(8'h00);
      applyStimulus(8'h90);
      @(negedge clk);
      checkOutput("word1 mem_we",   32'(bus.mem_we),   32'd1);
      checkOutput("word1 mem_addr", 32'(bus.mem_addr), 32'h01);
      checkOutput("word1 mem_din",  32'(bus.mem_din),  32'h090);
      applyStimulus(8'h75);
      @(negedge clk);
      checkOutput("good done pulse",     32'(bus.done),     32'd1);
      checkOutput("good cpu_hold k+1",   32'(bus.cpu_hold), 32'd1);
      checkOutput("good in_ready in DONE", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      checkOutput("good done end",       32'(bus.done),     32'd0);
      checkOutput("good cpu_hold k+2",   32'(bus.cpu_hold), 32'd0);
      checkOutput("good err",            32'(bus.err),      32'd0);
      idleCycles(3);
      checkOutput("good write count", 32'(wrAddr.size()), 32'd2);
      checkOutput("good done count",  32'(doneCount),     32'd1);

      // Bad checksum: words still written, err sticky, CPU kept held.
      clearLog();
      frame = '{8'hA5, 8'h02, 8'h00, 8'hF9, 8'h00, 8'h90, 8'h74};
      sendFrame();
      @(negedge clk);
      checkOutput("badsum err k+1",      32'(bus.err),      32'd1);
      checkOutput("badsum done k+1",     32'(bus.done),     32'd0);
      checkOutput("badsum cpu_hold k+1", 32'(bus.cpu_hold), 32'd1);
      idleCycles(5);
      checkOutput("badsum err sticky",      32'(bus.err),      32'd1);
      checkOutput("badsum cpu_hold sticky", 32'(bus.cpu_hold), 32'd1);
      checkOutput("badsum back to idle",    32'(bus.in_ready), 32'd1);
      checkOutput("badsum write count",     32'(wrAddr.size()), 32'd2);
      checkOutput("badsum addr1",           32'(wrAddr[1]),    32'h01);
      checkOutput("badsum data1",           32'(wrData[1]),    32'h090);
      checkOutput("badsum done count",      32'(doneCount),    32'd0);

      // Recovery frame clears err on sync and releases the CPU.
      clearLog();
      applyStimulus(8'hA5);
      @(negedge clk);
      checkOutput("recover err cleared", 32'(bus.err), 32'd0);
      frame = '{8'h02, 8'h00, 8'hF9, 8'h00, 8'h90, 8'h75};
      sendFrame();
      idleCycles(3);
      checkOutput("recover cpu_hold", 32'(bus.cpu_hold), 32'd0);
      checkOutput("recover err",      32'(bus.err),      32'd0);
      checkOutput("recover done",     32'(doneCount),    32'd1);

      // Leading garbage is discarded in IDLE.
      clearLog();
      frame = '{8'h00, 8'hFF, 8'h12};
      sendFrame();
      idleCycles(2);
      checkOutput("garbage writes",   32'(wrAddr.size()), 32'd0);
      checkOutput("garbage cpu_hold", 32'(bus.cpu_hold),  32'd0);
      frame = '{8'hA5, 8'h02, 8'h00, 8'hF9, 8'h00, 8'h90, 8'h75};
      sendFrame();
      idleCycles(3);
      checkOutput("garbage then frame writes", 32'(wrAddr.size()), 32'd2);
      checkOutput("garbage then frame data0",  32'(wrData[0]),     32'h0F9);
      checkOutput("garbage then frame done",   32'(doneCount),     32'd1);

      // Hi byte with non-zero upper nibble: word written, load rejected.
      clearLog();
      frame = '{8'hA5, 8'h02, 8'h1F, 8'hF9, 8'h00, 8'h90, 8'h56};
      sendFrame();
      idleCycles(3);
      checkOutput("nibble data0",    32'(wrData[0]),     32'hFF9);
      checkOutput("nibble writes",   32'(wrAddr.size()), 32'd2);
      checkOutput("nibble err",      32'(bus.err),       32'd1);
      checkOutput("nibble cpu_hold", 32'(bus.cpu_hold),  32'd1);
      checkOutput("nibble done",     32'(doneCount),     32'd0);

      // Count byte 0 means 256 words; word i carries value i, checksum 0x80.
      clearLog();
      applyStimulus(8'hA5);
      applyStimulus(8'h00);
      for (int i = 0; i < 256; i++) begin
         applyStimulus(8'h00);
         applyStimulus(8'(i));
      end
      applyStimulus(8'h80);
      @(negedge clk);
      checkOutput("full done pulse", 32'(bus.done), 32'd1);
      idleCycles(3);
      badEntries = 0;
      for (int i = 0; i < wrAddr.size(); i++) begin
         if (wrAddr[i] !== 8'(i) || wrData[i] !== 12'(i)) begin
            badEntries++;
         end
      end
      checkOutput("full write count", 32'(wrAddr.size()),            32'd256);
      checkOutput("full entries",     32'(badEntries),               32'd0);
      checkOutput("full last addr",   32'(wrAddr[wrAddr.size()-1]),  32'hFF);
      checkOutput("full last data",   32'(wrData[wrData.size()-1]),  32'h0FF);
      checkOutput("full cpu_hold",    32'(bus.cpu_hold),             32'd0);
      checkOutput("full err",         32'(bus.err),                  32'd0);

      // Reset after the third word of a five-word frame.
      clearLog();
      frame = '{8'hA5, 8'h05, 8'h00, 8'h11, 8'h00, 8'h22, 8'h00, 8'h33};
      sendFrame();
      idleCycles(2);
      checkOutput("midframe writes",   32'(wrAddr.size()), 32'd3);
      checkOutput("midframe cpu_hold", 32'(bus.cpu_hold),  32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      checkOutput("midreset mem_we",   32'(bus.mem_we),   32'd0);
      checkOutput("midreset cpu_hold", 32'(bus.cpu_hold), 32'd0);
      checkOutput("midreset err",      32'(bus.err),      32'd0);
      checkOutput("midreset in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      clearLog();
      frame = '{8'h05, 8'h00, 8'h44};
      sendFrame();
      idleCycles(3);
      checkOutput("post-reset writes",   32'(wrAddr.size()), 32'd0);
      checkOutput("post-reset cpu_hold", 32'(bus.cpu_hold),  32'd0);
      checkOutput("post-reset in_ready", 32'(bus.in_ready),  32'd1);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
